// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl
// Lock filtering and dynamic phase-step sequencing for an ECP5 EHXPLLL.
// The raw PLL LOCK is synchronised and debounced on the rising side only,
// producing locked_o and a set of per-domain resets. Phase-shift requests
// are turned into PHASESEL/PHASEDIR/PHASESTEP sequences with setup, pulse
// and settle timing. Losing lock aborts any sequence in flight.
module pll_phase_ctrl #(
  parameter int N_OUT       = 4,
  parameter int STEPS_W     = 8,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int LOCK_FILTER = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [STEPS_W-1:0] req_steps,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               locked_o,
  output logic [N_OUT-1:0]   rst_out_n,
  output logic [7:0]         lost_lock_cnt
);

  // Filter counter must be able to hold LOCK_FILTER itself (saturation value).
  localparam int LF_W    = $clog2(LOCK_FILTER + 1);
  // One shared phase timer sized for the longest of the three timed states.
  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] SETUP_LAST  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [LF_W-1:0]  LF_MAX      = LF_W'(LOCK_FILTER);
  localparam logic [2:0]       N_OUT_L     = 3'(N_OUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Lock synchroniser, filter and loss counter
  // ---------------------------------------------------------------------
  logic             sync1_q;
  logic             sync2_q;
  logic             lock_s;
  logic [LF_W-1:0]  filt_q;
  logic [LF_W-1:0]  filt_d;
  logic             locked_prev_q;
  logic [7:0]       lost_q;
  logic [7:0]       lost_d;
  logic [N_OUT-1:0] rst_out_q;

  assign lock_s = sync2_q;

  // Two-flop synchroniser for the asynchronous PLL LOCK pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  // Saturating run-length of synchronised lock; any low cycle restarts it.
  always_comb begin
    filt_d = filt_q;
    if (!lock_s) begin
      filt_d = '0;
    end else if (filt_q != LF_MAX) begin
      filt_d = filt_q + LF_W'(1);
    end
  end

  // Gating with lock_s makes loss visible on the very first low cycle.
  assign locked_o = lock_s && (filt_q == LF_MAX);

  // Count locked_o falling edges, stopping at 255.
  always_comb begin
    lost_d = lost_q;
    if (locked_prev_q && !locked_o && (lost_q != 8'hFF)) begin
      lost_d = lost_q + 8'd1;
    end
  end

  // Filter state, edge detector, loss counter and domain resets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q        <= '0;
      locked_prev_q <= 1'b0;
      lost_q        <= 8'd0;
      rst_out_q     <= '0;
    end else begin
      filt_q        <= filt_d;
      locked_prev_q <= locked_o;
      lost_q        <= lost_d;
      rst_out_q     <= {N_OUT{locked_o}};
    end
  end

  assign lost_lock_cnt = lost_q;
  assign rst_out_n     = rst_out_q;

  // ---------------------------------------------------------------------
  // Phase-step sequencer
  // ---------------------------------------------------------------------
  state_t             state_q;
  state_t             state_d;
  logic [TMR_W-1:0]   tmr_q;
  logic [TMR_W-1:0]   tmr_d;
  logic [STEPS_W-1:0] rem_q;
  logic [STEPS_W-1:0] rem_d;
  logic [1:0]         sel_q;
  logic [1:0]         sel_d;
  logic               dir_q;
  logic               dir_d;
  logic               err_q;
  logic               err_d;
  logic               phasestep_q;
  logic               phasestep_d;

  // Next-state, datapath updates and decoded outputs for the sequencer.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    rem_d       = rem_q;
    sel_d       = sel_q;
    dir_d       = dir_q;
    err_d       = 1'b0;
    req_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = locked_o;
        if (req_valid && locked_o) begin
          if ({1'b0, req_sel} >= N_OUT_L) begin
            // Unconnected output selected: reject without touching the PLL.
            err_d = 1'b1;
          end else begin
            sel_d = req_sel;
            dir_d = req_dir;
            rem_d = req_steps;
            tmr_d = '0;
            state_d = (req_steps == '0) ? S_DONE : S_SETUP;
          end
        end
      end

      S_SETUP, S_PULSE, S_SETTLE: begin
        if (!locked_o) begin
          // Lock lost mid-sequence: abort wins over any timer expiry.
          state_d = S_IDLE;
          err_d   = 1'b1;
          rem_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          if (state_q == S_SETUP) begin
            if (tmr_q == SETUP_LAST) begin
              tmr_d   = '0;
              state_d = S_PULSE;
            end
          end else if (state_q == S_PULSE) begin
            if (tmr_q == PULSE_LAST) begin
              tmr_d   = '0;
              rem_d   = rem_q - STEPS_W'(1);
              state_d = S_SETTLE;
            end
          end else begin
            if (tmr_q == SETTLE_LAST) begin
              tmr_d   = '0;
              // Further steps reuse the already-stable select/direction.
              state_d = (rem_q == '0) ? S_DONE : S_PULSE;
            end
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered so the PLL sees a glitch-free step strobe.
    phasestep_d = (state_d == S_PULSE);
  end

  // Sequencer state and held PLL control values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      rem_q       <= '0;
      sel_q       <= 2'd0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      phasestep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      phasestep_q <= phasestep_d;
    end
  end

  assign phasesel  = sel_q;
  assign phasedir  = dir_q;
  assign phasestep = phasestep_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl
// Directed bench: instance A has four outputs, instance B two, both with an
// 8-cycle lock filter and default phase timing. Inputs are shared.
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;

  logic       a_req_ready, a_phasedir, a_phasestep, a_busy, a_done, a_err, a_locked;
  logic [1:0] a_phasesel;
  logic [3:0] a_rst_out_n;
  logic [7:0] a_lost;

  logic       b_req_ready, b_phasedir, b_phasestep, b_busy, b_done, b_err, b_locked;
  logic [1:0] b_phasesel;
  logic [1:0] b_rst_out_n;
  logic [7:0] b_lost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pll_phase_ctrl #(.N_OUT(4), .LOCK_FILTER(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps),
    .phasesel(a_phasesel), .phasedir(a_phasedir), .phasestep(a_phasestep),
    .busy(a_busy), .done(a_done), .err(a_err),
    .locked_o(a_locked), .rst_out_n(a_rst_out_n), .lost_lock_cnt(a_lost)
  );

  pll_phase_ctrl #(.N_OUT(2), .LOCK_FILTER(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps),
    .phasesel(b_phasesel), .phasedir(b_phasedir), .phasestep(b_phasestep),
    .busy(b_busy), .done(b_done), .err(b_err),
    .locked_o(b_locked), .rst_out_n(b_rst_out_n), .lost_lock_cnt(b_lost)
  );

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    logic [7:0] steps;
    logic       poke;    // re-assert req_valid while busy
    int         done_a;  // cycle of done on A (0 = never)
    int         done_b;
    int         err_b;   // err pulses expected on B
    logic [1:0] sel_b;   // B phasesel after the window
    logic       dir_b;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_ctl"}, {a_req_ready, a_phasesel, a_phasedir, a_phasestep, a_busy, a_done, a_err}, 0);
    check({tag, "_a_lock"}, {a_locked, a_rst_out_n}, 0);
    check({tag, "_a_lost"}, a_lost, 0);
    check({tag, "_b_all"}, {b_req_ready, b_phasesel, b_phasedir, b_phasestep, b_busy, b_done, b_err,
                            b_locked, b_rst_out_n, b_lost}, 0);
  endtask

  // One request; window samples are cycle k+2 with the accept cycle as 1.
  task automatic run_vec(input int idx, input vec_t v);
    int  done_a = 0, ndone_a = 0, nerr_a = 0, busy_a = 0, hold_bad = 0, both = 0;
    int  pulses = 0, hirun = 0, lowrun = 0, width_bad = 0, gap_bad = 0;
    int  done_b = 0, nerr_b = 0, busy_b = 0, ps_b = 0;
    logic prev_ps = 1'b0;
    int  exp_busy_a, exp_busy_b;
    check($sformatf("v%0d_ready_a", idx), a_req_ready, 1);
    check($sformatf("v%0d_ready_b", idx), b_req_ready, 1);
    req_sel   = v.sel;
    req_dir   = v.dir;
    req_steps = v.steps;
    req_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (a_done) begin
        if (done_a == 0) done_a = k + 2;
        ndone_a++;
      end
      if (a_err) nerr_a++;
      if (a_done && a_err) both++;
      if (a_busy) begin
        busy_a++;
        if (a_phasesel != v.sel || a_phasedir != v.dir) hold_bad++;
      end
      if (a_phasestep) begin
        if (!prev_ps) begin
          pulses++;
          if (pulses > 1 && lowrun != 16) gap_bad++;
        end
        hirun++;
      end else if (prev_ps) begin
        if (hirun != 4) width_bad++;
        hirun  = 0;
        lowrun = 1;
      end else begin
        lowrun++;
      end
      prev_ps = a_phasestep;
      if (b_done && done_b == 0) done_b = k + 2;
      if (b_err) nerr_b++;
      if (b_busy) busy_b++;
      if (b_phasestep) ps_b++;
      if (b_done && b_err) both++;
      // drive after sampling
      if (k == 0) req_valid = 1'b0;
      if (v.poke && k == 8) begin
        req_valid = 1'b1;
        req_sel   = ~v.sel;
        req_dir   = ~v.dir;
      end
      if (v.poke && k == 9) req_valid = 1'b0;
    end
    exp_busy_a = (v.done_a != 0) ? v.done_a - 1 : 0;
    exp_busy_b = (v.done_b != 0) ? v.done_b - 1 : 0;
    check($sformatf("v%0d_done_cyc_a", idx), done_a, v.done_a);
    check($sformatf("v%0d_done_cnt_a", idx), ndone_a, (v.done_a != 0) ? 1 : 0);
    check($sformatf("v%0d_err_a", idx), nerr_a, 0);
    check($sformatf("v%0d_busy_a", idx), busy_a, exp_busy_a);
    check($sformatf("v%0d_hold_a", idx), hold_bad, 0);
    check($sformatf("v%0d_pulses_a", idx), pulses, v.steps);
    check($sformatf("v%0d_width_a", idx), width_bad, 0);
    check($sformatf("v%0d_gap_a", idx), gap_bad, 0);
    check($sformatf("v%0d_done_err_same", idx), both, 0);
    check($sformatf("v%0d_done_cyc_b", idx), done_b, v.done_b);
    check($sformatf("v%0d_err_b", idx), nerr_b, v.err_b);
    check($sformatf("v%0d_busy_b", idx), busy_b, exp_busy_b);
    check($sformatf("v%0d_ps_b", idx), ps_b, (v.err_b != 0) ? 0 : 4 * v.steps);
    check($sformatf("v%0d_sel_b", idx), {b_phasesel, b_phasedir}, {v.sel_b, v.dir_b});
    $display("vec %0d sel=%0d dir=%0d steps=%0d: A done@%0d pulses=%0d busy=%0d | B done@%0d err=%0d",
             idx, v.sel, v.dir, v.steps, done_a, pulses, busy_a, done_b, nerr_b);
  endtask

  initial begin
    int first_zero, nerr, ndone, nready, relock;

    // sel dir steps poke done_a done_b err_b sel_b dir_b
    vecs[0] = '{2'd1, 1'b0, 8'd1, 1'b1, 26, 26, 0, 2'd1, 1'b0};
    vecs[1] = '{2'd3, 1'b1, 8'd2, 1'b0, 46,  0, 1, 2'd1, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 8'd3, 1'b0, 66,  0, 1, 2'd1, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 8'd0, 1'b0,  2,  2, 0, 2'd0, 1'b0};
    vecs[4] = '{2'd0, 1'b1, 8'd1, 1'b0, 26, 26, 0, 2'd0, 1'b1};
    vecs[5] = '{2'd3, 1'b0, 8'd0, 1'b0,  2,  0, 1, 2'd0, 1'b1};

    rst_n = 1'b0; pll_lock = 1'b0; req_valid = 1'b0;
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
    repeat (3) tick();
    check_reset_vals("reset");
    pll_lock = 1'b1;
    tick();

    // Lock acquisition after release.
    rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 9) begin
        check("lock_e9_a", a_locked, 0);
        check("lock_e9_b", b_locked, 0);
      end
      if (e == 10) begin
        check("lock_e10_a", a_locked, 1);
        check("lock_e10_b", b_locked, 1);
        check("rstout_e10_a", a_rst_out_n, 4'h0);
      end
      if (e == 11) begin
        check("rstout_e11_a", a_rst_out_n, 4'hF);
        check("rstout_e11_b", b_rst_out_n, 2'h3);
        check("ready_e11_a", a_req_ready, 1);
      end
    end
    $display("lock: locked_a=%0d rst_out_n_a=%h after release", a_locked, a_rst_out_n);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Lock loss during the second pulse of a 5-step request.
    req_sel = 2'd1; req_dir = 1'b0; req_steps = 8'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 24; k++) tick();
    check("abort_pulse2_active", a_phasestep, 1);
    pll_lock = 1'b0;
    first_zero = 0; nerr = 0; ndone = 0; nready = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (!a_phasestep && first_zero == 0) first_zero = j;
      if (a_err) nerr++;
      if (a_done) ndone++;
      if (a_req_ready) nready++;
    end
    check("abort_ps_within3", (first_zero >= 1 && first_zero <= 3) ? 1 : 0, 1);
    check("abort_err_pulses", nerr, 1);
    check("abort_no_done", ndone, 0);
    check("abort_ready_low", nready, 0);
    check("abort_busy", a_busy, 0);
    check("abort_lost_a", a_lost, 1);
    check("abort_rstout_a", a_rst_out_n, 4'h0);
    check("abort_lost_b", b_lost, 1);
    $display("abort: phasestep low after %0d cycles, err=%0d done=%0d lost=%0d",
             first_zero, nerr, ndone, a_lost);

    // Relock, bounded wait.
    pll_lock = 1'b1;
    relock = 0;
    for (int j = 1; j <= 20 && relock == 0; j++) begin
      tick();
      if (a_req_ready) relock = j;
    end
    check("relock_cycles", relock, 10);
    $display("relock: ready after %0d cycles", relock);

    // Repeated lock loss, saturating counter.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (3) tick();
      pll_lock = 1'b1;
      repeat (12) tick();
      if (i == 99) check("lost_after_100", a_lost, 101);
    end
    check("lost_sat_a", a_lost, 255);
    check("lost_sat_b", b_lost, 255);
    $display("toggle: lost_a=%0d lost_b=%0d", a_lost, b_lost);

    // Asynchronous reset in the middle of SETTLE.
    req_sel = 2'd3; req_dir = 1'b1; req_steps = 8'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    check("pre_rst_busy", {a_busy, a_phasesel, a_phasedir, a_locked}, {1'b1, 2'd3, 1'b1, 1'b1});
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    $display("async reset: busy=%0d phasesel=%0d locked=%0d lost=%0d", a_busy, a_phasesel, a_locked, a_lost);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
